// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encoding,
// legal WIDTH range and the bit-counter width helper.
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // One spare bit so the counter can never wrap inside an operation.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder made of two half adders and an OR; this is the
// single arithmetic cell stepped once per clock by serial_add_ctrl.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; building block of the serial full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller: latches operands on start, runs one
// full-adder cell LSB-first for WIDTH cycles, then pulses done for one cycle.
// Defining SERIAL_ADD_OVF_EN adds the two's-complement overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,output logic             ovf
`endif
);

    // Handshake: start is sampled only while idle; the request is accepted on
    // that edge with a/b/cin captured. done is a one-cycle pulse during which
    // sum/cout are valid; they then hold until the next completed operation.

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] ps_shift;

    fa_cell u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    always_comb begin
        ps_shift          = ps_q >> 1;
        ps_shift[WIDTH-1] = cell_s;

        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ps_d    = ps_shift;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = cell_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = ps_shift;
                    cout_d  = cell_co;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this final step.
                    ovf_d   = carry_q ^ cell_co;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus
// random operations scored against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W+1:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
       ,.ovf   (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned sum of the three inputs; overflow from signed range.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int ux, uy, sx, sy, t, sr;
        logic [W+1:0] r;
        ux = x;
        uy = y;
        t  = ux + uy + (c ? 1 : 0);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        sr = sx + sy + (c ? 1 : 0);
        r[W:0] = t[W:0];
`ifdef SERIAL_ADD_OVF_EN
        r[W+1] = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
`else
        r[W+1] = 1'b0;
`endif
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got sum=0x%0h cout=%0b with no operation pending",
                         sum, cout);
            end else begin
                chk("result", {22'd0, ovf, cout, sum}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
        if (i >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy=%0b done=%0b required idle", busy, done);
        end
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        wait_idle();
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        exp_q.push_back(model(x, y, c));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (i >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_prev;
        int t_found;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum",  sum,  0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf",  ovf,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Latency: busy for W cycles after the start edge, done in cycle W+1.
        start_op(8'h5A, 8'h3C, 1'b0);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            chk("busy_shift", busy, 1);
            chk("no_early_done", done, 0);
        end
        @(negedge clk);
        chk("done_cycle", done, 1);
        chk("busy_in_done", busy, 0);
        chk("sum_5a_3c", sum, 8'h96);
        drain();

        start_op(8'hFF, 8'h01, 1'b0);
        drain();

        start_op(8'hFF, 8'h00, 1'b1);
        drain();
        repeat (20) begin
            @(negedge clk);
            chk("hold_sum", sum, 8'h00);
            chk("hold_cout", cout, 1);
            chk("hold_done", done, 0);
        end

        // start raised mid-operation must be ignored.
        start_op(8'h10, 8'h20, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (W + 4) @(negedge clk);
        chk("ignored_start_sum", sum, 8'h30);

        // Reset in the middle of an operation aborts it.
        start_op(8'h0F, 8'h01, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum",  sum,  0);
        chk("abort_cout", cout, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h01, 8'h01, 1'b0);
        drain();

        start_op(8'h7F, 8'h01, 1'b0);
        start_op(8'h80, 8'h80, 1'b0);
        start_op(8'h40, 8'h10, 1'b0);
        drain();

        // Held-high start: back-to-back operations every W+2 cycles.
        wait_idle();
        a     = 8'h33;
        b     = 8'h44;
        cin   = 1'b1;
        start = 1'b1;
        repeat (3) exp_q.push_back(model(8'h33, 8'h44, 1'b1));
        t_prev = 0;
        for (k = 0; k < 3; k++) begin
            int i;
            for (i = 0; i < 50; i++) begin
                @(negedge clk);
                if (done) break;
            end
            t_found = cyc;
            if (i >= 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL b2b_timeout: got no done required done pulse %0d", k);
            end else if (k > 0) begin
                chk("b2b_interval", t_found - t_prev, W + 2);
            end
            t_prev = t_found;
        end
        start = 1'b0;
        drain();

        // Random operations with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         c;
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            if ($urandom_range(0, 7) == 0) x = 8'hFF;
            if ($urandom_range(0, 7) == 0) y = 8'h80;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_op(x, y, c);
        end
        drain();
        repeat (W + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
